// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the decode/execute hazard sequencer:
// FSM encoding, forwarding select codes and the shadow slot layout.
package hazard_control_unit_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    localparam logic [REG_W-1:0] REG_X0 = '0;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_FLUSH    = 2'd2
    } hcu_state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } slot_t;

    // A load sitting in WB forwards like any other result, so WB drops the flag.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } wb_slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic slot_t make_slot(input logic             valid,
                                        input logic [REG_W-1:0] rd,
                                        input logic             is_load);
        slot_t s;
        s.valid   = valid && (rd != REG_X0);
        s.rd      = rd;
        s.is_load = is_load;
        return s;
    endfunction

endpackage

// File: rtl/hazard_forward_mux_sel.sv
// Per-operand forwarding select: picks regfile, MEM slot or WB slot for
// one source register key of the instruction in execute.
module hazard_forward_mux_sel
    import hazard_control_unit_pkg::*;
(
    input  logic [REG_W-1:0] key_i,
    input  slot_t            mem_slot_i,
    input  logic             wb_valid_i,
    input  logic [REG_W-1:0] wb_rd_i,
    output logic [1:0]       sel_o
);

    always_comb begin
        sel_o = FWD_REGFILE;
        if (key_i != REG_X0) begin
            // MEM is the younger producer and wins; loads in MEM have no data yet.
            if (mem_slot_i.valid && !mem_slot_i.is_load && (mem_slot_i.rd == key_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_valid_i && (wb_rd_i == key_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard sequencer around decode: load-use stall, MUL freeze, branch flush
// and forwarding selects. Optional counters under `HAZARD_STATS_EN.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_rd_en,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_is_load,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic             ex_is_mul,
    input  logic             ex_branch_taken,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             freeze_ex,
    output logic             kill_instr,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events
`endif
);

    localparam bit               MUL_FREEZES = (MUL_LATENCY > 1);
    localparam logic [CNT_W-1:0] MUL_LOAD    = MUL_FREEZES ? CNT_W'(MUL_LATENCY - 2) : '0;
    localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    hcu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_t            ex_q, ex_d, mem_q, mem_d, dec_slot;
    wb_slot_t         wb_q, wb_d;

    logic freeze, mul_start, branch_acc, kill, load_use, lu_stall;

    always_comb begin
        freeze     = (state_q == ST_MUL_BUSY);
        mul_start  = (state_q == ST_IDLE) && ex_is_mul && MUL_FREEZES;
        // Gated by reset so kill_instr stays low while the block is held in reset.
        branch_acc = reset && ex_branch_taken && !freeze && !mul_start;
        kill       = branch_acc || (state_q == ST_FLUSH);
        load_use   = dec_valid && ex_q.valid && ex_q.is_load &&
                     ((ex_q.rd == dec_rs1) || (ex_q.rd == dec_rs2));
        lu_stall   = load_use && !freeze && !kill;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    state_d = ST_MUL_BUSY;
                    cnt_d   = MUL_LOAD;
                end else if (branch_acc) begin
                    state_d = (FLUSH_LOAD == '0) ? ST_IDLE : ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            ST_MUL_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_FLUSH: begin
                // The branch cycle itself kills, so FLUSH covers the remaining cycles.
                if (branch_acc) begin
                    state_d = (FLUSH_LOAD == '0) ? ST_IDLE : ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        dec_slot = make_slot(dec_valid && dec_rd_en && !kill, dec_rd, dec_is_load);
        ex_d     = ex_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        if (!freeze) begin
            ex_d       = lu_stall ? SLOT_EMPTY : dec_slot;
            mem_d      = ex_q;
            wb_d.valid = mem_q.valid;
            wb_d.rd    = mem_q.rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    hazard_forward_mux_sel u_fwd_a (
        .key_i      (ex_rs1),
        .mem_slot_i (mem_q),
        .wb_valid_i (wb_q.valid),
        .wb_rd_i    (wb_q.rd),
        .sel_o      (fwd_sel_a)
    );

    hazard_forward_mux_sel u_fwd_b (
        .key_i      (ex_rs2),
        .mem_slot_i (mem_q),
        .wb_valid_i (wb_q.valid),
        .wb_rd_i    (wb_q.rd),
        .sel_o      (fwd_sel_b)
    );

    assign stall_fetch  = freeze || lu_stall;
    assign stall_decode = freeze || lu_stall;
    assign freeze_ex    = freeze;
    assign kill_instr   = kill;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, flush_events_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (stall_decode && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (branch_acc && (flush_events_q != '1)) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the decode/execute datapath.
- Tracks in-flight destination registers in shadow EX/MEM/WB slots.
- Drives stall, kill and forwarding selects around the decode stage.
- Freezes the pipe for multi-cycle MUL and flushes fetch/decode on a taken branch.

Parameters:
- MUL_LATENCY, 3, cycles a MUL occupies execute (1..15; 1 = no freeze)
- FLUSH_DEPTH, 2, cycles kill_instr is held after a taken branch (1..3)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- dec_valid  in  1  decode holds a real instruction
- dec_rs1  in  5  decode source1 register key
- dec_rs2  in  5  decode source2 register key
- dec_rd_en  in  1  decode instruction writes rd
- dec_rd  in  5  decode destination register number
- dec_is_load  in  1  decode instruction is LOAD
- ex_rs1  in  5  operand1_key of instruction in execute
- ex_rs2  in  5  operand2_key of instruction in execute
- ex_is_mul  in  1  execute holds MULTIPLICATION
- ex_branch_taken  in  1  execute resolved a taken branch/JALR
- stall_fetch  out  1  hold PC and fetch register
- stall_decode  out  1  hold decode register; insert bubble into execute
- freeze_ex  out  1  hold execute/mem/wb registers (MUL busy)
- kill_instr  out  1  to decode: substitute NOP
- fwd_sel_a  out  2  operand1 source: 00 regfile, 01 MEM slot, 10 WB slot
- fwd_sel_b  out  2  same for operand2

Behaviour:
- Reset (reset==0, async): all slots invalid; state IDLE; counters 0; all outputs 0.
- Shadow slot: {valid, rd, is_load}. Slots exist for EX, MEM and WB.
- Normal cycle: EX <= decode info (valid = dec_valid & dec_rd_en & ~kill_instr); MEM <= EX; WB <= MEM.
- Any slot with rd==x0 is stored invalid.
- Load-use stall (combinational):
  - Condition: dec_valid & EX.valid & EX.is_load & (EX.rd==dec_rs1 | EX.rd==dec_rs2).
  - Effect: stall_fetch = stall_decode = 1 for exactly one cycle.
  - EX <= bubble; MEM and WB advance.
- Forwarding (combinational, per operand, key k): k==0 -> 00; MEM.valid & ~MEM.is_load & MEM.rd==k -> 01; else WB.valid & WB.rd==k -> 10; else 00. MEM beats WB. A load in MEM is never forwarded; the load-use stall already guarantees it reaches WB first.
- FSM states: IDLE, MUL_BUSY, FLUSH.
  - IDLE -> MUL_BUSY when ex_is_mul & MUL_LATENCY>1. Counter loads MUL_LATENCY-2.
  - MUL_BUSY: freeze_ex = stall_fetch = stall_decode = 1; slots hold. Counter decrements; at 0 -> IDLE. Total freeze is MUL_LATENCY-1 cycles.
  - ex_branch_taken in IDLE (not frozen) -> FLUSH, counter loads FLUSH_DEPTH-1. kill_instr = 1 in the same cycle as ex_branch_taken and for FLUSH_DEPTH cycles total. FLUSH -> IDLE at counter 0.
- Priority: freeze > flush > load-use stall.
  - ex_branch_taken is ignored while freeze_ex=1 and sampled once the freeze ends.
  - Branch-flush with a pending load-use: stall suppressed; the killed instruction creates no slot.
  - ex_branch_taken during FLUSH restarts the counter.
- ex_is_mul is sampled only in IDLE. After MUL_BUSY exits, the same MUL is not re-triggered, because execute advances.
- Reset mid-MUL or mid-FLUSH aborts to IDLE with all outputs 0.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both saturating at 32'hFFFF_FFFF and reset to 0.
  - stall_cycles increments on every cycle with stall_decode=1.
  - flush_events increments once per IDLE->FLUSH or FLUSH-restart.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/include (alongside ALU and RISC-V constants):
  - FSM state encodings
  - FWD_REGFILE/FWD_MEM/FWD_WB codes
  - slot struct field widths
  - x0 constant
- One natural sub-module: hazard_forward_mux_sel. Purely combinational; one instance per operand, computes fwd_sel from key and MEM/WB slots.

Test Plan:
- LOAD x5 in decode, next cycle ADD x6,x5,x1 in decode -> stall_decode=1 for exactly 1 cycle; then ADD in EX with fwd_sel_a=10.
- ADDI x3,x0,7 then ADD x4,x3,x3 -> no stall; fwd_sel_a=fwd_sel_b=01 when ADD in EX.
- MUL in EX, MUL_LATENCY=3 -> freeze_ex=1 for 2 cycles; ex_branch_taken pulsed during the freeze is ignored.
- ex_branch_taken=1 with FLUSH_DEPTH=2 and load-use pending -> kill_instr high 2 cycles; stall_decode=0; no slot created for the killed instruction.
- Writes to x0 followed by reader of x0 -> fwd_sel=00, no stall.
- reset pulled low mid-MUL_BUSY -> all outputs 0 asynchronously; after release, the first instruction proceeds without stall.
